fifo_ptr_flag: RTL

//  Parametrised async-FIFO pointer/flag block: one instance per clock domain (MODE selects write or read side).

---
 rtl/fifo_ptr_flag.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_ptr_flag.sv
// Async-FIFO pointer/flag block for one clock domain. It keeps binary and Gray pointers and a remote-pointer
// synchroniser, and registers full|empty, almost, fill level and a sticky overflow/underflow error.
module fifo_ptr_flag #(
  parameter int ADDR        = 5,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_TH   = 4
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            op_i,
  input  logic [ADDR:0]   remote_gray_i,
  input  logic            clr_err_i,
  output logic            en_o,
  output logic [ADDR-1:0] addr_o,
  output logic [ADDR:0]   ptr_bin_o,
  output logic [ADDR:0]   ptr_gray_o,
  output logic            status_o,
  output logic            almost_o,
  output logic [ADDR:0]   level_o,
  output logic            err_o
);
  localparam int            PW           = ADDR + 1;
  localparam logic [PW-1:0] DEPTH        = PW'(2 ** ADDR);
  localparam logic [PW-1:0] TH           = PW'(ALMOST_TH);
  localparam logic          RESET_STATUS = (MODE != 0);

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] rsync, rbin;
  logic [PW-1:0] bin_q, bin_d, gray_q, gray_d, level_q, level_d;
  logic          status_q, status_d, almost_q, almost_d, err_q, err_d;

  // Plain flop chain: no logic between stages so each bit resolves independently.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], remote_gray_i};
  end

  assign rsync = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) rbin[i] = ^(rsync >> i);
  end

  always_comb begin
    en_o   = op_i & ~status_q;
    bin_d  = bin_q + {{ADDR{1'b0}}, en_o};
    gray_d = bin_d ^ (bin_d >> 1);
    err_d  = (op_i & status_q) | (err_q & ~clr_err_i);
    if (MODE == 0) begin
      // Full when the write pointer is exactly one lap ahead of the read pointer.
      status_d = (gray_d == {~rsync[ADDR:ADDR-1], rsync[ADDR-2:0]});
      level_d  = bin_d - rbin;
      almost_d = (level_d >= DEPTH - TH);
    end else begin
      status_d = (gray_d == rsync);
      level_d  = rbin - bin_d;
      almost_d = (level_d <= TH);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      status_q <= RESET_STATUS;
      almost_q <= RESET_STATUS;
      err_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      status_q <= status_d;
      almost_q <= almost_d;
      err_q    <= err_d;
    end
  end

  assign addr_o     = bin_q[ADDR-1:0];
  assign ptr_bin_o  = bin_q;
  assign ptr_gray_o = gray_q;
  assign status_o   = status_q;
  assign almost_o   = almost_q;
  assign level_o    = level_q;
  assign err_o      = err_q;

endmodule
